// File: rtl/bmem_arbiter_pkg.sv
// Shared types and sizing for the cacheline-to-bmem arbiter.
// Line geometry is fixed here so the interface, top and bench agree on widths.
package bmem_arbiter_pkg;

  localparam int BEAT_W    = 64;
  localparam int BURST_LEN = 4;
  localparam int LINE_W    = BEAT_W * BURST_LEN;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_DATA,
    WR_BURST,
    RESP
  } arb_state_t;

  typedef enum logic {
    CLIENT_I,
    CLIENT_D
  } arb_client_t;

  function automatic arb_client_t other_client(input arb_client_t c);
    return (c == CLIENT_I) ? CLIENT_D : CLIENT_I;
  endfunction

endpackage

// File: rtl/bmem_arbiter_if.sv
// Cache-client and bmem-side signal bundle of the arbiter.
// master = arbiter view, slave = caches/memory view.
interface bmem_arbiter_if;
  import bmem_arbiter_pkg::*;

  logic [31:0]       i_addr;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic [31:0]       d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [31:0]       bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  logic              proto_err;

  modport master (
    input  i_addr, i_read,
    output i_rdata, i_resp,
    input  d_addr, d_read, d_write, d_wdata,
    output d_rdata, d_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output proto_err
  );

  modport slave (
    output i_addr, i_read,
    input  i_rdata, i_resp,
    output d_addr, d_read, d_write, d_wdata,
    input  d_rdata, d_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  proto_err
  );

endinterface

// File: rtl/bmem_arbiter_line_deserializer.sv
// Beat counter plus line buffer: collects read beats into slots and
// presents the current write beat from a loaded line.
module bmem_arbiter_line_deserializer #(
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4,
  localparam int LINE_W   = BEAT_W * BURST_LEN,
  localparam int CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              store,
  input  logic [BEAT_W-1:0] beat,
  input  logic              adv,
  output logic              last,
  output logic [LINE_W-1:0] line,
  output logic [LINE_W-1:0] line_nxt,
  output logic [BEAT_W-1:0] cur_beat
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;

  assign last     = (cnt_q == CNT_W'(BURST_LEN - 1));
  assign line     = line_q;
  assign cur_beat = line_q[cnt_q*BEAT_W +: BEAT_W];

  // line_nxt is the buffer as it will look once the incoming beat lands
  always_comb begin
    line_nxt = line_q;
    line_nxt[cnt_q*BEAT_W +: BEAT_W] = beat;
    line_d = line_q;
    cnt_d  = cnt_q;
    if (load) begin
      line_d = load_line;
      cnt_d  = '0;
    end else if (store || adv) begin
      if (store) line_d = line_nxt;
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/bmem_arbiter.sv
// Round-robin arbiter between I-cache and D-cache that turns whole-line
// requests into 64-bit bmem bursts, one transaction in flight at a time.
module bmem_arbiter
  import bmem_arbiter_pkg::*;
(
  input logic            clk,
  input logic            rst,
  bmem_arbiter_if.master bus
);

  arb_state_t  state_q, state_d;
  arb_client_t client_q, client_d;
  arb_client_t rr_last_q, rr_last_d;
  arb_client_t gnt;
  logic [31:0] addr_q, addr_d;
  logic        resp_prev_q;
  logic        perr_q, perr_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic        i_resp_q, i_resp_d, d_resp_q, d_resp_d;
  logic        bmem_read_q, bmem_read_d, bmem_write_q, bmem_write_d;
  logic [31:0] bmem_addr_q, bmem_addr_d;

  logic i_req, d_req, gnt_wr, beat_hit;
  logic buf_load, beat_store, beat_adv;
  logic last_beat;
  logic [LINE_W-1:0] line_buf, line_nxt;
  logic [BEAT_W-1:0] wbeat;

  bmem_arbiter_line_deserializer #(
    .BEAT_W   (BEAT_W),
    .BURST_LEN(BURST_LEN)
  ) u_deser (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .load_line(bus.d_wdata),
    .store    (beat_store),
    .beat     (bus.bmem_rdata),
    .adv      (beat_adv),
    .last     (last_beat),
    .line     (line_buf),
    .line_nxt (line_nxt),
    .cur_beat (wbeat)
  );

  always_comb begin
    state_d    = state_q;
    client_d   = client_q;
    rr_last_d  = rr_last_q;
    addr_d     = addr_q;
    perr_d     = perr_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    gnt        = CLIENT_I;
    gnt_wr     = 1'b0;
    buf_load   = 1'b0;
    beat_store = 1'b0;
    beat_adv   = 1'b0;
    // a client whose resp just pulsed may still hold its request for a cycle
    i_req    = bus.i_read && !(resp_prev_q && client_q == CLIENT_I);
    d_req    = (bus.d_read || bus.d_write) && !(resp_prev_q && client_q == CLIENT_D);
    beat_hit = bus.bmem_rvalid && (bus.bmem_raddr == addr_q);

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          if (i_req && d_req) gnt = other_client(rr_last_q);
          else                gnt = d_req ? CLIENT_D : CLIENT_I;
          client_d  = gnt;
          rr_last_d = gnt;
          if (gnt == CLIENT_D) begin
            addr_d = bus.d_addr;
            gnt_wr = bus.d_write;
          end else begin
            addr_d = bus.i_addr;
          end
          buf_load = gnt_wr;
          state_d  = gnt_wr ? WR_BURST : RD_CMD;
        end
        if (bus.bmem_rvalid) perr_d = 1'b1;
      end
      RD_CMD: begin
        if (bus.bmem_ready) state_d = RD_DATA;
        if (bus.bmem_rvalid) perr_d = 1'b1;
      end
      RD_DATA: begin
        if (beat_hit) begin
          beat_store = 1'b1;
          if (last_beat) begin
            state_d = RESP;
            if (client_q == CLIENT_I) i_rdata_d = line_nxt;
            else                      d_rdata_d = line_nxt;
          end
        end else if (bus.bmem_rvalid) begin
          perr_d = 1'b1;
        end
      end
      WR_BURST: begin
        if (bus.bmem_ready) begin
          beat_adv = 1'b1;
          if (last_beat) begin
            state_d   = RESP;
            d_rdata_d = line_buf;
          end
        end
        if (bus.bmem_rvalid) perr_d = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        if (bus.bmem_rvalid) perr_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // outputs are decoded from the next state so they leave a flop
    bmem_read_d  = (state_d == RD_CMD);
    bmem_write_d = (state_d == WR_BURST);
    bmem_addr_d  = (bmem_read_d || bmem_write_d) ? addr_d : '0;
    i_resp_d     = (state_d == RESP) && (client_d == CLIENT_I);
    d_resp_d     = (state_d == RESP) && (client_d == CLIENT_D);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      client_q     <= CLIENT_I;
      rr_last_q    <= CLIENT_I;
      addr_q       <= '0;
      resp_prev_q  <= 1'b0;
      perr_q       <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
      bmem_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      client_q     <= client_d;
      rr_last_q    <= rr_last_d;
      addr_q       <= addr_d;
      resp_prev_q  <= (state_q == RESP);
      perr_q       <= perr_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_resp_q     <= i_resp_d;
      d_resp_q     <= d_resp_d;
      bmem_read_q  <= bmem_read_d;
      bmem_write_q <= bmem_write_d;
      bmem_addr_q  <= bmem_addr_d;
    end
  end

  assign bus.i_rdata    = i_rdata_q;
  assign bus.i_resp     = i_resp_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.d_resp     = d_resp_q;
  assign bus.bmem_addr  = bmem_addr_q;
  assign bus.bmem_read  = bmem_read_q;
  assign bus.bmem_write = bmem_write_q;
  assign bus.bmem_wdata = bmem_write_q ? wbeat : '0;
  assign bus.proto_err  = perr_q;

endmodule
